// File: rtl/fix_parser_wide.sv
// FIX tag/value stream parser with mod-256 checksum check; all outputs registered, one cycle after the accepted byte.
// Consumes one byte per in_valid cycle with no stall; there is no backpressure.
module fix_parser_wide #(
  parameter int TAG_CHARS = 3,
  parameter int VAL_CHARS = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [7:0]             data_in,
  output logic [8*TAG_CHARS-1:0] tag,
  output logic                   tag_valid,
  output logic [8*VAL_CHARS-1:0] value,
  output logic [7:0]             value_len,
  output logic                   value_valid,
  output logic                   value_overflow,
  output logic [7:0]             checksum_calc,
  output logic                   checksum_ok,
  output logic                   checksum_err,
  output logic                   msg_done,
  output logic                   msg_abort,
  output logic [1:0]             state
);

  localparam int TW  = 8 * TAG_CHARS;
  localparam int VW  = 8 * VAL_CHARS;
  localparam int TCW = $clog2(TAG_CHARS + 1);
  localparam logic [TCW-1:0] LP_TAG_MAX   = TCW'(TAG_CHARS);
  localparam logic [7:0]     LP_VAL_CHARS = 8'(VAL_CHARS);
  localparam logic [TW-1:0]  LP_TAG_10    = TW'(16'h3130);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TAG   = 2'd1,
    ST_VALUE = 2'd2,
    ST_CSUM  = 2'd3
  } state_t;

  state_t         r_state;
  logic [TW-1:0]  r_tag;
  logic [TCW-1:0] r_tag_cnt;
  logic [VW-1:0]  r_value;
  logic [7:0]     r_len;
  logic [7:0]     r_acc;
  logic [7:0]     r_acc_snap;
  logic [9:0]     r_cs_val;
  logic [1:0]     r_cs_cnt;
  logic           r_cs_bad;
  logic           r_tag_valid;
  logic           r_value_valid;
  logic           r_value_ovf;
  logic           r_cs_ok;
  logic           r_cs_err;
  logic           r_msg_done;
  logic           r_msg_abort;

  logic          w_digit;
  logic          w_soh;
  logic          w_eq;
  logic [TW-1:0] w_tag_shift;
  logic [VW-1:0] w_val_shift;
  logic [7:0]    w_len_inc;
  logic [7:0]    w_acc_add;
  logic [9:0]    w_cs_next;
  logic          w_cs_match;
  logic          w_ovf;

  assign w_digit     = (data_in >= 8'h30) && (data_in <= 8'h39);
  assign w_soh       = (data_in == 8'h01);
  assign w_eq        = (data_in == 8'h3D);
  assign w_tag_shift = (r_tag << 8) | TW'(data_in);
  assign w_val_shift = (r_value << 8) | VW'(data_in);
  assign w_len_inc   = (r_len == 8'hFF) ? r_len : r_len + 8'd1;
  assign w_acc_add   = r_acc + data_in;
  assign w_cs_next   = r_cs_val * 10'd10 + {6'd0, data_in[3:0]};
  // The 10-bit accumulator must be below 256 as well as match, so "439" is not accepted for 183.
  assign w_cs_match  = !r_cs_bad && (r_cs_val < 10'd256) && (r_cs_val[7:0] == r_acc_snap);
  assign w_ovf       = (r_len > LP_VAL_CHARS);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= ST_IDLE;
      r_tag         <= '0;
      r_tag_cnt     <= '0;
      r_value       <= '0;
      r_len         <= '0;
      r_acc         <= '0;
      r_acc_snap    <= '0;
      r_cs_val      <= '0;
      r_cs_cnt      <= '0;
      r_cs_bad      <= 1'b0;
      r_tag_valid   <= 1'b0;
      r_value_valid <= 1'b0;
      r_value_ovf   <= 1'b0;
      r_cs_ok       <= 1'b0;
      r_cs_err      <= 1'b0;
      r_msg_done    <= 1'b0;
      r_msg_abort   <= 1'b0;
    end else begin
      r_tag_valid   <= 1'b0;
      r_value_valid <= 1'b0;
      r_value_ovf   <= 1'b0;
      r_cs_ok       <= 1'b0;
      r_cs_err      <= 1'b0;
      r_msg_done    <= 1'b0;
      r_msg_abort   <= 1'b0;
      if (in_valid) begin
        case (r_state)
          ST_IDLE: begin
            if (data_in == 8'h38) begin
              r_tag     <= TW'(8'h38);
              r_tag_cnt <= TCW'(1);
              r_acc     <= 8'h38;
              r_state   <= ST_TAG;
            end
          end

          ST_TAG: begin
            r_acc <= w_acc_add;
            if (w_digit && (r_tag_cnt != LP_TAG_MAX)) begin
              r_tag     <= w_tag_shift;
              r_tag_cnt <= r_tag_cnt + TCW'(1);
            end else if (w_eq && (r_tag_cnt != '0)) begin
              r_tag_valid <= 1'b1;
              r_value     <= '0;
              r_len       <= '0;
              if (r_tag == LP_TAG_10) begin
                r_cs_val <= '0;
                r_cs_cnt <= '0;
                r_cs_bad <= 1'b0;
                r_state  <= ST_CSUM;
              end else begin
                r_state <= ST_VALUE;
              end
            end else begin
              r_msg_abort <= 1'b1;
              r_tag       <= '0;
              r_tag_cnt   <= '0;
              r_state     <= ST_IDLE;
            end
          end

          ST_VALUE: begin
            r_acc <= w_acc_add;
            if (w_soh) begin
              r_value_valid <= 1'b1;
              r_value_ovf   <= w_ovf;
              // Snapshot covers every byte up to and including this SOH, i.e. before the next tag.
              r_acc_snap    <= w_acc_add;
              r_tag         <= '0;
              r_tag_cnt     <= '0;
              r_state       <= ST_TAG;
            end else begin
              r_value <= w_val_shift;
              r_len   <= w_len_inc;
            end
          end

          ST_CSUM: begin
            if (w_soh) begin
              r_value_valid <= 1'b1;
              r_value_ovf   <= w_ovf;
              r_msg_done    <= 1'b1;
              r_cs_ok       <= w_cs_match;
              r_cs_err      <= !w_cs_match;
              r_state       <= ST_IDLE;
            end else begin
              r_value <= w_val_shift;
              r_len   <= w_len_inc;
              if (w_digit && (r_cs_cnt != 2'd3)) begin
                r_cs_val <= w_cs_next;
                r_cs_cnt <= r_cs_cnt + 2'd1;
              end else begin
                r_cs_bad <= 1'b1;
              end
            end
          end

          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign tag            = r_tag;
  assign tag_valid      = r_tag_valid;
  assign value          = r_value;
  assign value_len      = r_len;
  assign value_valid    = r_value_valid;
  assign value_overflow = r_value_ovf;
  assign checksum_calc  = r_acc_snap;
  assign checksum_ok    = r_cs_ok;
  assign checksum_err   = r_cs_err;
  assign msg_done       = r_msg_done;
  assign msg_abort      = r_msg_abort;
  assign state          = r_state;

endmodule
